// File: rtl/frame_fifo_read_cam_if.sv
// Burst-read bus between frame_fifo_read_cam and the memory controller.
//   rd_burst_req    : request, held until rd_burst_finish
//   rd_burst_len    : burst length in words
//   rd_burst_addr   : burst base word address
//   rd_burst_finish : one-cycle pulse, burst complete
// master = frame reader, slave = memory controller.
interface frame_fifo_read_cam_if #(
    parameter int ADDR_BITS  = 28,
    parameter int BUSRT_BITS = 10
);
    logic                  rd_burst_req;
    logic [BUSRT_BITS-1:0] rd_burst_len;
    logic [ADDR_BITS-1:0]  rd_burst_addr;
    logic                  rd_burst_finish;

    modport master (
        output rd_burst_req,
        output rd_burst_len,
        output rd_burst_addr,
        input  rd_burst_finish
    );

    modport slave (
        input  rd_burst_req,
        input  rd_burst_len,
        input  rd_burst_addr,
        output rd_burst_finish
    );
endinterface

// File: rtl/frame_fifo_read_cam.sv
// Frame burst reader: after the camera writer has landed a frame in external
// memory, fetches it from one of two base addresses through the memory
// controller's burst-read port into an output FIFO. Runs in mem_clk only;
// read_req, read_len and read_addr_index are synchronized internally.
//
// Ports:
//   mem_clk, rst      : clock, synchronous active-high reset
//   rd_bus (master)   : burst-read request/len/addr, finish pulse
//   read_req/_ack     : consumer frame-read handshake (read_req async)
//   read_addr_0/_1    : frame base addresses, chosen by read_addr_index
//   read_len          : frame length in words
//   frame_valid       : writer has a complete frame; gates acceptance
//   fifo_aclr         : output FIFO clear, asserted with read_req_ack
//   wrusedw           : output FIFO used words (write side)
//   read_finish       : one-cycle pulse when the frame is fetched
//
// Build option: define READ_TAIL_BURST_EN to trim the last burst so exactly
// read_len words are fetched; otherwise every burst is BURST_SIZE words.
module frame_fifo_read_cam #(
    parameter int MEM_DATA_BITS = 32,
    parameter int ADDR_BITS     = 28,
    parameter int BUSRT_BITS    = 10,
    parameter int BURST_SIZE    = 128,
    parameter int FIFO_DEPTH    = 512
) (
    input  logic                    mem_clk,
    input  logic                    rst,
    frame_fifo_read_cam_if.master   rd_bus,
    input  logic                    read_req,
    output logic                    read_req_ack,
    input  logic [ADDR_BITS-1:0]    read_addr_0,
    input  logic [ADDR_BITS-1:0]    read_addr_1,
    input  logic                    read_addr_index,
    input  logic [ADDR_BITS-1:0]    read_len,
    input  logic                    frame_valid,
    output logic                    fifo_aclr,
    input  logic [15:0]             wrusedw,
    output logic                    read_finish
);

    // Elaboration-time configuration guard.
    if (FIFO_DEPTH < 2 * BURST_SIZE || MEM_DATA_BITS <= 0) begin : g_bad_cfg
        $error("frame_fifo_read_cam: FIFO_DEPTH must be >= 2*BURST_SIZE");
    end

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        CHECK_FIFO,
        READ_BURST,
        READ_BURST_END,
        END
    } state_t;

    state_t                 state;
    logic                   req_d0, req_d1, req_d2;
    logic                   index_d0, index_d1;
    logic [ADDR_BITS-1:0]   len_d0, len_d1;
    logic [ADDR_BITS-1:0]   len_latch;
    logic [ADDR_BITS-1:0]   read_cnt;
    logic [BUSRT_BITS-1:0]  burst_len_next;
    logic                   space_ok;

`ifdef READ_TAIL_BURST_EN
    logic [ADDR_BITS-1:0]   remaining;

    // Last burst is trimmed to the words still owed; FIFO room is checked
    // against the length actually about to be requested.
    always_comb begin
        remaining = len_latch - read_cnt;
        if (remaining < ADDR_BITS'(BURST_SIZE))
            burst_len_next = BUSRT_BITS'(remaining);
        else
            burst_len_next = BUSRT_BITS'(BURST_SIZE);
        space_ok = (wrusedw <= (16'(FIFO_DEPTH) - 16'(burst_len_next)));
    end
`else
    always_comb begin
        burst_len_next = BUSRT_BITS'(BURST_SIZE);
        space_ok       = (wrusedw <= 16'(FIFO_DEPTH - BURST_SIZE));
    end
`endif

    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state                <= IDLE;
            req_d0               <= 1'b0;
            req_d1               <= 1'b0;
            req_d2               <= 1'b0;
            index_d0             <= 1'b0;
            index_d1             <= 1'b0;
            len_d0               <= '0;
            len_d1               <= '0;
            len_latch            <= '0;
            read_cnt             <= '0;
            rd_bus.rd_burst_req  <= 1'b0;
            rd_bus.rd_burst_len  <= '0;
            rd_bus.rd_burst_addr <= '0;
            read_req_ack         <= 1'b0;
            fifo_aclr            <= 1'b0;
            read_finish          <= 1'b0;
        end else begin
            req_d0   <= read_req;
            req_d1   <= req_d0;
            req_d2   <= req_d1;
            index_d0 <= read_addr_index;
            index_d1 <= index_d0;
            len_d0   <= read_len;
            len_d1   <= len_d0;

            case (state)
                IDLE: begin
                    read_req_ack <= 1'b0;
                    read_finish  <= 1'b0;
                    // Without a landed frame the request simply stays pending.
                    if (req_d2 && frame_valid)
                        state <= ACK;
                end

                ACK: begin
                    if (req_d2) begin
                        read_req_ack         <= 1'b1;
                        fifo_aclr            <= 1'b1;
                        rd_bus.rd_burst_addr <= index_d1 ? read_addr_1 : read_addr_0;
                        len_latch            <= len_d1;
                        read_cnt             <= '0;
                    end else begin
                        read_req_ack <= 1'b0;
                        fifo_aclr    <= 1'b0;
                        state        <= (len_latch == '0) ? END : CHECK_FIFO;
                    end
                end

                CHECK_FIFO: begin
                    if (req_d2) begin
                        state <= ACK;
                    end else if (space_ok) begin
                        rd_bus.rd_burst_len <= burst_len_next;
                        rd_bus.rd_burst_req <= 1'b1;
                        state               <= READ_BURST;
                    end
                end

                // A burst is never truncated; a new request waits for finish.
                READ_BURST: begin
                    if (rd_bus.rd_burst_finish) begin
                        rd_bus.rd_burst_req  <= 1'b0;
                        read_cnt             <= read_cnt + ADDR_BITS'(rd_bus.rd_burst_len);
                        rd_bus.rd_burst_addr <= rd_bus.rd_burst_addr + ADDR_BITS'(rd_bus.rd_burst_len);
                        state                <= READ_BURST_END;
                    end
                end

                READ_BURST_END: begin
                    if (req_d2)
                        state <= ACK;
                    else if (read_cnt < len_latch)
                        state <= CHECK_FIFO;
                    else
                        state <= END;
                end

                END: begin
                    read_finish <= 1'b1;
                    state       <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_fifo_read_cam.sv
// Directed testbench for frame_fifo_read_cam. Acts as consumer and as the
// memory controller's burst-read port; expected values are hand-computed.
module tb_frame_fifo_read_cam;

    logic        mem_clk;
    logic        rst;
    logic        read_req;
    logic        read_req_ack;
    logic [27:0] read_addr_0;
    logic [27:0] read_addr_1;
    logic        read_addr_index;
    logic [27:0] read_len;
    logic        frame_valid;
    logic        fifo_aclr;
    logic [15:0] wrusedw;
    logic        read_finish;

    int checks   = 0;
    int failures = 0;

    frame_fifo_read_cam_if #(.ADDR_BITS(28), .BUSRT_BITS(10)) bus ();

    frame_fifo_read_cam #(
        .MEM_DATA_BITS(32),
        .ADDR_BITS(28),
        .BUSRT_BITS(10),
        .BURST_SIZE(128),
        .FIFO_DEPTH(512)
    ) dut (
        .mem_clk(mem_clk),
        .rst(rst),
        .rd_bus(bus.master),
        .read_req(read_req),
        .read_req_ack(read_req_ack),
        .read_addr_0(read_addr_0),
        .read_addr_1(read_addr_1),
        .read_addr_index(read_addr_index),
        .read_len(read_len),
        .frame_valid(frame_valid),
        .fifo_aclr(fifo_aclr),
        .wrusedw(wrusedw),
        .read_finish(read_finish)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Consumer handshake: raise read_req, wait for ack, drop it, wait for ack low.
    task automatic request(input string tag, input logic idx, input logic [27:0] len,
                           input logic [31:0] exp_base);
        read_addr_index = idx;
        read_len        = len;
        read_req        = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (read_req_ack) break;
        end
        chk({tag, "_ack_rise"}, 32'(read_req_ack), 32'd1);
        chk({tag, "_aclr"}, 32'(fifo_aclr), 32'd1);
        chk({tag, "_base"}, 32'(bus.rd_burst_addr), exp_base);
        read_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!read_req_ack) break;
        end
        chk({tag, "_ack_fall"}, 32'(read_req_ack), 32'd0);
        chk({tag, "_aclr_fall"}, 32'(fifo_aclr), 32'd0);
    endtask

    // Memory controller side of one burst.
    task automatic serve_burst(input string tag, input logic [31:0] exp_addr,
                               input logic [31:0] exp_len);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.rd_burst_req) break;
        end
        chk({tag, "_req"}, 32'(bus.rd_burst_req), 32'd1);
        chk({tag, "_addr"}, 32'(bus.rd_burst_addr), exp_addr);
        chk({tag, "_len"}, 32'(bus.rd_burst_len), exp_len);
        tick(); tick(); tick();
        chk({tag, "_hold_req"}, 32'(bus.rd_burst_req), 32'd1);
        chk({tag, "_hold_addr"}, 32'(bus.rd_burst_addr), exp_addr);
        bus.rd_burst_finish = 1'b1;
        tick();
        bus.rd_burst_finish = 1'b0;
        chk({tag, "_req_drop"}, 32'(bus.rd_burst_req), 32'd0);
    endtask

    task automatic wait_finish(input string tag);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (read_finish) break;
        end
        chk({tag, "_finish"}, 32'(read_finish), 32'd1);
        chk({tag, "_no_req_at_finish"}, 32'(bus.rd_burst_req), 32'd0);
        tick();
        chk({tag, "_finish_1cyc"}, 32'(read_finish), 32'd0);
    endtask

    initial begin
        int   cnt;
        logic seen;

        rst                 = 1'b1;
        read_req            = 1'b0;
        read_addr_0         = 28'h0100000;
        read_addr_1         = 28'h0200000;
        read_addr_index     = 1'b0;
        read_len            = '0;
        frame_valid         = 1'b1;
        wrusedw             = 16'd0;
        bus.rd_burst_finish = 1'b0;
        tick(); tick(); tick();

        chk("rst_req", 32'(bus.rd_burst_req), 32'd0);
        chk("rst_len", 32'(bus.rd_burst_len), 32'd0);
        chk("rst_addr", 32'(bus.rd_burst_addr), 32'd0);
        chk("rst_ack", 32'(read_req_ack), 32'd0);
        chk("rst_aclr", 32'(fifo_aclr), 32'd0);
        chk("rst_finish", 32'(read_finish), 32'd0);
        rst = 1'b0;
        tick();

        // 1: 1024-word frame from base 0 -> eight 128-word bursts.
        request("t1", 1'b0, 28'd1024, 32'h100000);
        for (int b = 0; b < 8; b++)
            serve_burst($sformatf("t1_b%0d", b), 32'h100000 + 32'(b) * 32'h80, 32'd128);
        wait_finish("t1");

        // 2: request held while no frame is valid.
        frame_valid = 1'b0;
        read_addr_index = 1'b0;
        read_len = 28'd128;
        read_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            seen |= read_req_ack;
        end
        chk("t2_no_ack_invalid", 32'(seen), 32'd0);
        frame_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt++;
            if (read_req_ack) break;
        end
        chk("t2_ack_after_valid", 32'(read_req_ack), 32'd1);
        chk("t2_ack_within_4", 32'(cnt <= 4), 32'd1);
        read_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!read_req_ack) break;
        end
        chk("t2_ack_fall", 32'(read_req_ack), 32'd0);
        serve_burst("t2_b0", 32'h100000, 32'd128);
        wait_finish("t2");

        // 3: FIFO back-pressure; threshold is 512-128 = 384.
        wrusedw = 16'd400;
        request("t3", 1'b0, 28'd128, 32'h100000);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            seen |= bus.rd_burst_req;
        end
        chk("t3_no_req_400", 32'(seen), 32'd0);
        wrusedw = 16'd384;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt++;
            if (bus.rd_burst_req) break;
        end
        chk("t3_req_at_384", 32'(bus.rd_burst_req), 32'd1);
        chk("t3_req_latency", 32'(cnt <= 2), 32'd1);
        wrusedw = 16'd0;
        serve_burst("t3_b0", 32'h100000, 32'd128);
        wait_finish("t3");

        // 4: new request (index 1) while a burst is in flight.
        request("t4a", 1'b0, 28'd1024, 32'h100000);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.rd_burst_req) break;
        end
        chk("t4_first_req", 32'(bus.rd_burst_req), 32'd1);
        read_addr_index = 1'b1;
        read_len = 28'd256;
        read_req = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("t4_no_truncate", 32'(bus.rd_burst_req), 32'd1);
        chk("t4_addr_stable", 32'(bus.rd_burst_addr), 32'h100000);
        bus.rd_burst_finish = 1'b1;
        tick();
        bus.rd_burst_finish = 1'b0;
        chk("t4_req_drop", 32'(bus.rd_burst_req), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (read_req_ack) break;
        end
        chk("t4_reack", 32'(read_req_ack), 32'd1);
        chk("t4_aclr", 32'(fifo_aclr), 32'd1);
        chk("t4_new_base", 32'(bus.rd_burst_addr), 32'h200000);
        read_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!read_req_ack) break;
        end
        chk("t4_ack_fall", 32'(read_req_ack), 32'd0);
        // read_cnt restarted at 0: two full bursts for 256 words.
        serve_burst("t4_b0", 32'h200000, 32'd128);
        serve_burst("t4_b1", 32'h200080, 32'd128);
        wait_finish("t4");

        // 5: 300-word frame.
        request("t5", 1'b0, 28'd300, 32'h100000);
        serve_burst("t5_b0", 32'h100000, 32'd128);
        serve_burst("t5_b1", 32'h100080, 32'd128);
`ifdef READ_TAIL_BURST_EN
        serve_burst("t5_b2", 32'h100100, 32'd44);
`else
        serve_burst("t5_b2", 32'h100100, 32'd128);
`endif
        wait_finish("t5");

        // 6a: zero-length frame never issues a burst.
        request("t6", 1'b0, 28'd0, 32'h100000);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen |= bus.rd_burst_req;
            if (read_finish) break;
        end
        chk("t6_finish", 32'(read_finish), 32'd1);
        chk("t6_no_burst", 32'(seen), 32'd0);
        tick();
        chk("t6_finish_1cyc", 32'(read_finish), 32'd0);

        // 6b: reset while a burst is outstanding.
        request("t7", 1'b0, 28'd128, 32'h100000);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.rd_burst_req) break;
        end
        chk("t7_req", 32'(bus.rd_burst_req), 32'd1);
        rst = 1'b1;
        tick();
        chk("t7_rst_req", 32'(bus.rd_burst_req), 32'd0);
        chk("t7_rst_len", 32'(bus.rd_burst_len), 32'd0);
        chk("t7_rst_addr", 32'(bus.rd_burst_addr), 32'd0);
        chk("t7_rst_ack", 32'(read_req_ack), 32'd0);
        chk("t7_rst_aclr", 32'(fifo_aclr), 32'd0);
        chk("t7_rst_finish", 32'(read_finish), 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen |= bus.rd_burst_req | read_finish | read_req_ack;
        end
        chk("t7_quiet_after_rst", 32'(seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/frame_fifo_read_cam.md
Name: frame_fifo_read_cam

Overview:
Burst-read stage directly downstream of the camera frame writer. Once a frame has landed in external memory, it fetches that frame from one of two base addresses. Data goes through the memory controller's burst-read port into an output FIFO, which feeds the face-detection / display pipeline. Runs entirely in the mem_clk domain. The consumer's request is treated as asynchronous and is synchronized internally.

Parameters:
MEM_DATA_BITS, 32, memory data width (bookkeeping only; data path bypasses this block)
ADDR_BITS, 28, memory word-address width
BUSRT_BITS, 10, burst-length field width
BURST_SIZE, 128, words per normal burst
FIFO_DEPTH, 512, output FIFO depth in words; must be >= 2*BURST_SIZE

Ports:
mem_clk  input  1  memory controller user clock; all logic on rising edge
rst  input  1  synchronous active-high reset
rd_burst_req  output  1  burst-read request to memory controller; held until rd_burst_finish
rd_burst_len  output  BUSRT_BITS  burst length in words
rd_burst_addr  output  ADDR_BITS  burst base word address
rd_burst_finish  input  1  one-cycle pulse: burst complete
read_req  input  1  consumer frame-read request (async); held 1 until read_req_ack
read_req_ack  output  1  request response
read_addr_0  input  ADDR_BITS  frame base used when read_addr_index=0
read_addr_1  input  ADDR_BITS  frame base used when read_addr_index=1
read_addr_index  input  1  selects base address (async; synchronized)
read_len  input  ADDR_BITS  frame length in words (async; synchronized)
frame_valid  input  1  writer has completed a frame (level, mem_clk domain); gates request acceptance
fifo_aclr  output  1  output FIFO clear
wrusedw  input  16  output FIFO write-side used words
read_finish  output  1  one-cycle pulse: frame fully fetched

Behaviour:
- Synchronizers: read_req through 3 flops (req_d2 used). read_len and read_addr_index through 2 flops (d1 used).
- Reset values: rd_burst_req=0, rd_burst_len=0, rd_burst_addr=0, read_req_ack=0, fifo_aclr=0, read_finish=0. Internal state: state=IDLE, read_cnt=0, len_latch=0. Synchronizer flops are cleared to 0.
- Reset asserted mid-burst: rd_burst_req drops on the next edge and no finish is awaited. The controller must tolerate an abandoned request.
- IDLE: read_req_ack=0, read_finish=0. If req_d2=1 and frame_valid=1, go to ACK. If req_d2=1 and frame_valid=0, stay in IDLE (request remains pending).
- ACK, while req_d2=1: read_req_ack=1, fifo_aclr=1, rd_burst_addr = index_d1 ? read_addr_1 : read_addr_0, len_latch=len_d1, read_cnt=0.
- ACK, when req_d2=0: read_req_ack=0, fifo_aclr=0. If len_latch=0, go to END; otherwise go to CHECK_FIFO.
- CHECK_FIFO, in priority order:
  - req_d2=1: go to ACK (restart).
  - else if wrusedw <= FIFO_DEPTH-BURST_SIZE: set rd_burst_len and rd_burst_req=1, go to READ_BURST.
  - else stay.
- READ_BURST: hold rd_burst_req, rd_burst_len and rd_burst_addr stable. On rd_burst_finish:
  - rd_burst_req=0
  - read_cnt += current burst length
  - rd_burst_addr += current burst length
  - go to READ_BURST_END
- READ_BURST_END, in priority order:
  - req_d2=1: go to ACK.
  - else if read_cnt < len_latch: go to CHECK_FIFO.
  - else go to END.
- END: read_finish=1 for exactly one cycle, then IDLE.
- Arithmetic: read_cnt and rd_burst_addr are ADDR_BITS wide and wrap modulo 2^ADDR_BITS; no overflow detection. The FIFO-space comparison is 16-bit unsigned.
- A new request arriving during READ_BURST is not honoured until the burst completes; no burst is ever truncated.
- Minimum gap between consecutive bursts: 2 cycles (READ_BURST_END, then CHECK_FIFO).

Optional Feature:
Macro: READ_TAIL_BURST_EN.
- Defined: the final burst length is min(BURST_SIZE, len_latch-read_cnt), so exactly len_latch words are fetched. The FIFO-space check uses that length.
- Undefined: every burst is BURST_SIZE. The frame is rounded up to a multiple of BURST_SIZE, and read_cnt may exceed len_latch at END.

Test Plan:
1. Request with read_addr_index=0, read_addr_0=0x100000, read_len=1024, frame_valid=1, FIFO draining freely -> 8 bursts of length 128 at addresses 0x100000, 0x100080, ... 0x100380. read_finish pulses once.
2. Request with frame_valid=0 held 50 cycles, then frame_valid set to 1 -> no read_req_ack before frame_valid rises; ack appears within 4 cycles after it rises.
3. Back-pressure: wrusedw held at 400 (FIFO_DEPTH=512) -> no rd_burst_req. When wrusedw drops to 384, a burst issues on the next CHECK_FIFO cycle.
4. Second read_req (index=1, read_addr_1=0x200000) asserted mid-frame -> the in-flight burst completes, fifo_aclr pulses, and the next burst starts at 0x200000 with read_cnt=0.
5. read_len=300 -> with READ_TAIL_BURST_EN: bursts 128,128,44, total 300. Without it: 3 bursts of 128, total 384.
6. read_len=0 -> ack handshake completes, read_finish pulses, and no rd_burst_req is ever asserted. Also: rst asserted during READ_BURST -> all outputs return to 0 on the next edge.
